// File: rtl/decoder_arb_pkg.sv
// Shared types and constants for the round-robin select arbiter.
// Pure declarations; no logic, no latency, no flow control.
package decoder_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ = 8;
    localparam int IDX_W = 3;
    localparam logic [NUM_REQ-1:0] SEL_IDLE = 8'hFF;

endpackage

// File: rtl/sel_decoder_3to8_n.sv
// 3-to-8 decoder producing an active-low one-hot select, all ones when disabled.
// Combinational, zero latency; no flow control.
module sel_decoder_3to8_n
    import decoder_arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] sel_n
);

    always_comb begin
        sel_n = SEL_IDLE;
        if (en) begin
            sel_n[idx] = 1'b0;
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// 8-way round-robin arbiter driving a registered active-low one-hot select; ARB_TIMEOUT_EN adds forced release.
// Grant appears one edge after the request is sampled; one idle cycle between grants; requesters hold req until granted.
module decoder_rr_arbiter
    import decoder_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt_n,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be within 1..255");
    end

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               to_nxt;
    logic               rel;
    logic               hold_hit;
    logic               grant_nxt;
    logic [IDX_W:0]     pick;
    logic [NUM_REQ-1:0] sel_nxt;

    // Returns {found, index} of the first request at or after p, wrapping past 7.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] c;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            c = p + IDX_W'(i);
            if (r[c]) begin
                res = {1'b1, c};
            end
        end
        return res;
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;

    assign hold_hit = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= 8'd0;
        end else if (state == GRANT && state_nxt == GRANT) begin
            hold_cnt <= hold_cnt + 8'd1;
        end else begin
            hold_cnt <= 8'd0;
        end
    end
`else
    assign hold_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = gnt_idx;
        to_nxt    = 1'b0;
        rel       = 1'b0;
        pick      = rr_pick(req, ptr);
        case (state)
            IDLE: begin
                if (en && pick[IDX_W]) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick[IDX_W-1:0];
                end
            end
            GRANT: begin
                if (!en || !req[gnt_idx]) begin
                    rel = 1'b1;
                end else if (hold_hit) begin
                    rel    = 1'b1;
                    to_nxt = 1'b1;
                end
                if (rel) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    ptr_nxt   = gnt_idx + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_nxt = (state_nxt == GRANT);

    sel_decoder_3to8_n u_dec (
        .idx   (idx_nxt),
        .en    (grant_nxt),
        .sel_n (sel_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            gnt_n   <= SEL_IDLE;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt_idx <= idx_nxt;
            gnt_n   <= sel_nxt;
            timeout <= to_nxt;
        end
    end

    assign gnt_valid = (state == GRANT);

endmodule
